cheri_stkz_lsu_arb: RTL and testbench
=====================================

Name: cheri_stkz_lsu_arb

Overview:
Responder side of the stack-zeroization LSU request interface. Arbitrates background zeroization stores against core load/store requests onto a single OBI-style data bus. Returns per-request done, response-valid and response-error to the zeroization engine, and grant/response to the core LSU path. Sits between the LSU request generator and the data memory port.

Parameters:
DataWidth, 33, memory data width incl. tag bits; legal 32, 33, 65

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
core_req_i  in  1  core LSU request; held stable until core_gnt_o
core_we_i  in  1  core write enable
core_is_cap_i  in  1  core capability access
core_addr_i  in  32  core address
core_be_i  in  4  core byte enables
core_wdata_i  in  DataWidth  core write data
core_gnt_o  out  1  core request accepted by bus
core_rvalid_o  out  1  core response valid
core_err_o  out  1  core response error
core_rdata_o  out  DataWidth  core read data
stkz_req_i  in  1  zeroization request; held until stkz_req_done_o
stkz_we_i  in  1  zeroization write enable
stkz_is_cap_i  in  1  zeroization cap-width store
stkz_addr_i  in  32  zeroization address (word aligned)
stkz_wdata_i  in  DataWidth  zeroization write data
stkz_abort_i  in  1  zeroization engine waiting to abort
stkz_req_done_o  out  1  zeroization request consumed
stkz_resp_valid_o  out  1  zeroization response valid
stkz_resp_err_o  out  1  zeroization response error
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_we_o  out  1  bus write enable
data_is_cap_o  out  1  bus cap access
data_addr_o  out  32  bus address
data_be_o  out  4  bus byte enables
data_wdata_o  out  DataWidth  bus write data
data_rvalid_i  in  1  bus response valid
data_err_i  in  1  bus response error
data_rdata_i  in  DataWidth  bus read data
busy_o  out  1  transaction in flight (FSM != IDLE)

Behaviour:
- Reset: rst_ni asynchronous, active-low; clock clk_i. FSM=IDLE, owner_q=CORE, all registered state 0; with no inputs active every output is 0.
- FSM states: IDLE, REQ (request on bus, not granted, owner locked), RESP (granted, awaiting rvalid).
- IDLE: sel = core if core_req_i else stkz if stkz_req_i. data_req_o = core_req_i|stkz_req_i. Core has fixed priority. gnt same cycle -> RESP, owner_q<=sel; no gnt -> REQ, owner_q<=sel.
- REQ: data_req_o=1, mux locked to owner_q regardless of other master (OBI: no retraction, no switch); on gnt -> RESP.
- RESP: data_req_o=0 (base build); on data_rvalid_i -> IDLE. New request may be arbitrated in IDLE the following cycle (no same-cycle rvalid/req overlap in base build).
- Mux: data_we/is_cap/addr/be/wdata from selected master; stkz be forced 4'hF.
- core_gnt_o = data_gnt_i & data_req_o & (selected==CORE). stkz_req_done_o = (data_gnt_i & data_req_o & selected==STKZ) | (stkz_abort_i & core_gnt_o) — core activity retires a pending abort.
- core_rvalid_o/core_err_o = data_rvalid_i/data_err_i & owner_q==CORE & state==RESP; stkz_resp_valid_o/err likewise for STKZ. core_rdata_o = data_rdata_i. Combinational, zero latency.
- data_rvalid_i in IDLE/REQ: ignored, no output pulse.
- stkz_abort_i while stkz owns REQ: bus held until gnt; done pulses on gnt.
- Reset mid-REQ/RESP: immediate return to IDLE, outputs 0; bus-side recovery is system responsibility.

Optional Feature:
CHERI_STKZ_LSU_PIPE_EN: two outstanding transactions. 2-entry owner FIFO replaces owner_q; arbitration/grant permitted while RESP if FIFO not full; responses routed in order from FIFO head; simultaneous push/pop allowed; full FIFO blocks data_req_o. Without macro: single outstanding, behaviour as above.

Test Plan:
- stkz_req_i=1, addr 0x2000_0FF8, is_cap=1, gnt same cycle, rvalid next -> data_be_o=4'hF, stkz_req_done_o pulse at gnt, stkz_resp_valid_o 1 cycle later, err=0.
- core_req_i and stkz_req_i both 1 in IDLE, gnt immediate -> core_gnt_o first; stkz granted in first IDLE cycle after core rvalid.
- stkz in REQ, gnt delayed 3 cycles, core_req_i rises cycle 1 -> data_addr_o stays 0x2000_0FF8, core_gnt_o=0 until after stkz rvalid.
- stkz response data_err_i=1 -> stkz_resp_err_o=1, core_err_o=0; core response err -> only core_err_o.
- stkz_abort_i=1, core load granted -> stkz_req_done_o and core_gnt_o pulse same cycle.
- rst_ni low during RESP -> busy_o=0, all outputs 0; spurious rvalid after reset produces no response pulse.

Source files
------------

// File: rtl/cheri_stkz_lsu_arb.sv
`default_nettype none
// ============================================================================
// Module      : cheri_stkz_lsu_arb
// Description : Arbitrates stack-zeroization stores against core LSU requests
//               onto one OBI-style data port. The core has fixed priority.
//               Once a request is on the bus, the mux is locked to its owner.
//               Responses are routed back to the owner of the transaction.
// Option      : CHERI_STKZ_LSU_PIPE_EN enables two outstanding transactions
//               tracked by a 2-entry owner FIFO. When undefined, only one
//               transaction may be outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module cheri_stkz_lsu_arb #(
  parameter int unsigned DataWidth = 33
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_req_i,
  input  logic                 core_we_i,
  input  logic                 core_is_cap_i,
  input  logic [31:0]          core_addr_i,
  input  logic [3:0]           core_be_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  output logic                 core_gnt_o,
  output logic                 core_rvalid_o,
  output logic                 core_err_o,
  output logic [DataWidth-1:0] core_rdata_o,
  input  logic                 stkz_req_i,
  input  logic                 stkz_we_i,
  input  logic                 stkz_is_cap_i,
  input  logic [31:0]          stkz_addr_i,
  input  logic [DataWidth-1:0] stkz_wdata_i,
  input  logic                 stkz_abort_i,
  output logic                 stkz_req_done_o,
  output logic                 stkz_resp_valid_o,
  output logic                 stkz_resp_err_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  output logic                 data_we_o,
  output logic                 data_is_cap_o,
  output logic [31:0]          data_addr_o,
  output logic [3:0]           data_be_o,
  output logic [DataWidth-1:0] data_wdata_o,
  input  logic                 data_rvalid_i,
  input  logic                 data_err_i,
  input  logic [DataWidth-1:0] data_rdata_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Owner encoding: 0 = core, 1 = zeroization engine.
  state_e r_state;
  state_e w_state_d;
  logic   w_arb_ok;      // a fresh arbitration may happen this cycle
  logic   w_locked;      // a request is on the bus waiting for grant
  logic   w_lock_owner;
  logic   w_resp_ok;     // a response is expected this cycle
  logic   w_resp_owner;
  logic   w_sel_stkz;
  logic   w_accept;

`ifdef CHERI_STKZ_LSU_PIPE_EN
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_d;
  logic [1:0] r_fifo;
  logic       r_rd;
  logic       r_wr;
  logic       r_locked;
  logic       r_lock_owner;
  logic       w_push;
  logic       w_pop;

  assign w_arb_ok     = ~r_locked & (r_cnt != 2'd2);
  assign w_locked     = r_locked;
  assign w_lock_owner = r_lock_owner;
  assign w_resp_ok    = (r_cnt != 2'd0);
  assign w_resp_owner = r_fifo[r_rd];
  assign w_push       = w_accept;
  assign w_pop        = data_rvalid_i & w_resp_ok;

  // Next occupancy and the summarised state used for busy reporting.
  always_comb begin
    w_cnt_d   = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    w_state_d = IDLE;
    if (data_req_o && !data_gnt_i) begin
      w_state_d = REQ;
    end else if (w_cnt_d != 2'd0) begin
      w_state_d = RESP;
    end
  end

  // Owner FIFO and request lock; simultaneous push and pop are allowed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt        <= 2'd0;
      r_fifo       <= 2'b00;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_locked     <= 1'b0;
      r_lock_owner <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_d;
      r_locked <= data_req_o & ~data_gnt_i;
      if (w_push) begin
        r_fifo[r_wr] <= w_sel_stkz;
        r_wr         <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      if (data_req_o && !r_locked) begin
        r_lock_owner <= w_sel_stkz;
      end
    end
  end
`else
  logic r_owner;
  logic w_owner_d;

  assign w_arb_ok     = (r_state == IDLE);
  assign w_locked     = (r_state == REQ);
  assign w_lock_owner = r_owner;
  assign w_resp_ok    = (r_state == RESP);
  assign w_resp_owner = r_owner;

  // Single-outstanding next-state: IDLE -> (REQ) -> RESP -> IDLE.
  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    case (r_state)
      IDLE: begin
        if (data_req_o) begin
          w_owner_d = w_sel_stkz;
          w_state_d = data_gnt_i ? RESP : REQ;
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          w_state_d = RESP;
        end
      end
      RESP: begin
        if (data_rvalid_i) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Owner register for the transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner <= 1'b0;
    end else begin
      r_owner <= w_owner_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Arbitration, bus mux, grant and response routing.
  always_comb begin
    w_sel_stkz = w_locked ? w_lock_owner : (~core_req_i & stkz_req_i);
    data_req_o = w_locked | (w_arb_ok & (core_req_i | stkz_req_i));
    w_accept   = data_req_o & data_gnt_i;

    data_we_o     = w_sel_stkz ? stkz_we_i     : core_we_i;
    data_is_cap_o = w_sel_stkz ? stkz_is_cap_i : core_is_cap_i;
    data_addr_o   = w_sel_stkz ? stkz_addr_i   : core_addr_i;
    data_be_o     = w_sel_stkz ? 4'hF          : core_be_i;
    data_wdata_o  = w_sel_stkz ? stkz_wdata_i  : core_wdata_i;

    core_gnt_o      = w_accept & ~w_sel_stkz;
    // Any core grant also retires a pending zeroization abort.
    stkz_req_done_o = (w_accept & w_sel_stkz) | (stkz_abort_i & core_gnt_o);

    core_rvalid_o     = data_rvalid_i & w_resp_ok & ~w_resp_owner;
    core_err_o        = data_err_i    & w_resp_ok & ~w_resp_owner & data_rvalid_i;
    stkz_resp_valid_o = data_rvalid_i & w_resp_ok &  w_resp_owner;
    stkz_resp_err_o   = data_err_i    & w_resp_ok &  w_resp_owner & data_rvalid_i;
    core_rdata_o      = data_rdata_i;

    busy_o = (r_state != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_cheri_stkz_lsu_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cheri_stkz_lsu_arb
// Description : Directed bench for cheri_stkz_lsu_arb. Stimulus pushes the
//               expected handshake/response events into a queue, and a
//               negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cheri_stkz_lsu_arb;

  localparam int DW = 33;
  localparam logic [31:0] STKZ_ADDR = 32'h2000_0FF8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          core_req_i, core_we_i, core_is_cap_i;
  logic [31:0]   core_addr_i;
  logic [3:0]    core_be_i;
  logic [DW-1:0] core_wdata_i;
  logic          core_gnt_o, core_rvalid_o, core_err_o;
  logic [DW-1:0] core_rdata_o;
  logic          stkz_req_i, stkz_we_i, stkz_is_cap_i;
  logic [31:0]   stkz_addr_i;
  logic [DW-1:0] stkz_wdata_i;
  logic          stkz_abort_i;
  logic          stkz_req_done_o, stkz_resp_valid_o, stkz_resp_err_o;
  logic          data_req_o, data_gnt_i, data_we_o, data_is_cap_o;
  logic [31:0]   data_addr_o;
  logic [3:0]    data_be_o;
  logic [DW-1:0] data_wdata_o;
  logic          data_rvalid_i, data_err_i;
  logic [DW-1:0] data_rdata_i;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  cheri_stkz_lsu_arb #(.DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_is_cap_i(core_is_cap_i),
    .core_addr_i(core_addr_i), .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_err_o(core_err_o),
    .core_rdata_o(core_rdata_o),
    .stkz_req_i(stkz_req_i), .stkz_we_i(stkz_we_i), .stkz_is_cap_i(stkz_is_cap_i),
    .stkz_addr_i(stkz_addr_i), .stkz_wdata_i(stkz_wdata_i), .stkz_abort_i(stkz_abort_i),
    .stkz_req_done_o(stkz_req_done_o), .stkz_resp_valid_o(stkz_resp_valid_o),
    .stkz_resp_err_o(stkz_resp_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_is_cap_o(data_is_cap_o), .data_addr_o(data_addr_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
    .data_rdata_i(data_rdata_i), .busy_o(busy_o)
  );

  // flags = {core_gnt, stkz_done, core_rvalid, core_err, stkz_rvalid, stkz_err}
  typedef struct {
    logic [5:0]    flags;
    logic [37:0]   bus;    // {we, is_cap, be, addr} checked on grant events
    logic [DW-1:0] rdata;  // checked on core responses
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void expect_ev(input logic [5:0] f, input logic we, input logic cap,
                                    input logic [3:0] be, input logic [31:0] a,
                                    input logic [DW-1:0] rd);
    ev_t e;
    e.flags = f;
    e.bus   = {we, cap, be, a};
    e.rdata = rd;
    exp_q.push_back(e);
  endfunction

  function automatic logic [13:0] all_outs();
    return {core_gnt_o, core_rvalid_o, core_err_o, |core_rdata_o, stkz_req_done_o,
            stkz_resp_valid_o, stkz_resp_err_o, data_req_o, data_we_o, data_is_cap_o,
            |data_addr_o, |data_be_o, |data_wdata_o, busy_o};
  endfunction

  // Monitor: every handshake/response pulse must match the next expected event.
  always @(negedge clk_i) begin
    logic [5:0] obs;
    ev_t        e;
    obs = {core_gnt_o, stkz_req_done_o, core_rvalid_o, core_err_o,
           stkz_resp_valid_o, stkz_resp_err_o};
    if (obs != 6'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {58'b0, obs}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("event_flags", {58'b0, obs}, {58'b0, e.flags});
        if (e.flags[5] || e.flags[4])
          chk("grant_bus", {26'b0, data_we_o, data_is_cap_o, data_be_o, data_addr_o},
              {26'b0, e.bus});
        if (e.flags[3] || (e.flags[2] && !e.flags[5]))
          chk("core_rdata", {{(64-DW){1'b0}}, core_rdata_o}, {{(64-DW){1'b0}}, e.rdata});
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    core_req_i = 0; core_we_i = 0; core_is_cap_i = 0; core_addr_i = '0;
    core_be_i = '0; core_wdata_i = '0;
    stkz_req_i = 0; stkz_we_i = 0; stkz_is_cap_i = 0; stkz_addr_i = '0;
    stkz_wdata_i = '0; stkz_abort_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = '0;
  endtask

  task automatic stkz_drive();
    stkz_req_i = 1; stkz_we_i = 1; stkz_is_cap_i = 1; stkz_addr_i = STKZ_ADDR;
  endtask

  initial begin
    rst_ni = 0;
    clr();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outputs", {50'b0, all_outs()}, 64'h0);
    step(); rst_ni = 1;
    @(negedge clk_i);
    chk("post_reset_outputs", {50'b0, all_outs()}, 64'h0);

    // Zeroization store, immediate grant, response next cycle.
    step(); stkz_drive(); data_gnt_i = 1;
    expect_ev(6'b010000, 1, 1, 4'hF, STKZ_ADDR, '0);
    @(negedge clk_i); chk("stkz_busy_after_gnt_cycle", {63'b0, busy_o}, 64'h0);
    step(); clr(); data_rvalid_i = 1;
    expect_ev(6'b000010, 0, 0, 4'h0, 32'h0, '0);
    @(negedge clk_i); chk("busy_in_resp", {63'b0, busy_o}, 64'h1);
    step(); clr();
    @(negedge clk_i); chk("idle_after_resp", {63'b0, busy_o}, 64'h0);

    // Both masters request: core first, stkz in first IDLE after core rvalid.
    step(); stkz_drive();
    core_req_i = 1; core_addr_i = 32'h0000_0100; core_be_i = 4'h3; data_gnt_i = 1;
    expect_ev(6'b100000, 0, 0, 4'h3, 32'h0000_0100, '0);
    step(); core_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = 33'h1_DEAD_BEEF;
    expect_ev(6'b001000, 0, 0, 4'h0, 32'h0, 33'h1_DEAD_BEEF);
    @(negedge clk_i); chk("no_req_in_resp", {63'b0, data_req_o}, 64'h0);
    step(); data_rvalid_i = 0; data_rdata_i = '0; data_gnt_i = 1;
    expect_ev(6'b010000, 1, 1, 4'hF, STKZ_ADDR, '0);
    step(); clr(); data_rvalid_i = 1;
    expect_ev(6'b000010, 0, 0, 4'h0, 32'h0, '0);
    step(); clr();

    // Stkz locked in REQ for 3 cycles while the core requests.
    step(); stkz_drive();
    for (int i = 1; i <= 2; i++) begin
      step();
      core_req_i = 1; core_we_i = 1; core_addr_i = 32'h0000_0300; core_be_i = 4'hC;
      core_wdata_i = 33'h0_1234_5678;
      @(negedge clk_i);
      chk("locked_addr", {32'b0, data_addr_o}, {32'b0, STKZ_ADDR});
      chk("locked_core_gnt", {62'b0, core_gnt_o, data_req_o}, 64'h1);
    end
    step(); data_gnt_i = 1;
    expect_ev(6'b010000, 1, 1, 4'hF, STKZ_ADDR, '0);
    step(); stkz_req_i = 0; data_gnt_i = 0; data_rvalid_i = 1; data_err_i = 1;
    expect_ev(6'b000011, 0, 0, 4'h0, 32'h0, '0);
    @(negedge clk_i); chk("core_gnt_in_stkz_resp", {63'b0, core_gnt_o}, 64'h0);
    step(); data_rvalid_i = 0; data_err_i = 0; data_gnt_i = 1;
    expect_ev(6'b100000, 1, 0, 4'hC, 32'h0000_0300, '0);
    step(); clr(); data_rvalid_i = 1; data_err_i = 1;
    expect_ev(6'b001100, 0, 0, 4'h0, 32'h0, '0);
    step(); clr();

    // Abort retired by a core load grant.
    step(); stkz_abort_i = 1; core_req_i = 1; core_addr_i = 32'h0000_0400;
    core_be_i = 4'hF; data_gnt_i = 1;
    expect_ev(6'b110000, 0, 0, 4'hF, 32'h0000_0400, '0);
    step(); clr(); data_rvalid_i = 1; data_rdata_i = 33'h0_CAFE_0001;
    expect_ev(6'b001000, 0, 0, 4'h0, 32'h0, 33'h0_CAFE_0001);
    step(); clr();

    // Spurious rvalid in IDLE.
    step(); data_rvalid_i = 1; data_err_i = 1;
    @(negedge clk_i); chk("idle_rvalid_ignored", {62'b0, core_rvalid_o, stkz_resp_valid_o}, 64'h0);
    step(); clr();

    // Reset while in RESP.
    step(); core_req_i = 1; core_addr_i = 32'h0000_0500; core_be_i = 4'h1; data_gnt_i = 1;
    expect_ev(6'b100000, 0, 0, 4'h1, 32'h0000_0500, '0);
    step(); clr(); rst_ni = 0;
    @(negedge clk_i); chk("reset_in_resp", {50'b0, all_outs()}, 64'h0);
    step(); rst_ni = 1;
    step(); data_rvalid_i = 1; data_err_i = 1;
    @(negedge clk_i); chk("rvalid_after_reset", {60'b0, core_rvalid_o, core_err_o,
                                                 stkz_resp_valid_o, stkz_resp_err_o}, 64'h0);
    step(); clr();

    repeat (3) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
